// File: rtl/rf_operand_fetch.sv
// Operand-fetch stage: pending-write scoreboard, RAW/WAW stall, one-entry output buffer.
// Optional writeback-to-operand bypass enabled by defining RF_BYPASS_EN.
module rf_operand_fetch #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_id_valid,
  output logic               o_id_ready,
  input  logic [BW_ADDR-1:0] i_id_rs0_addr,
  input  logic [BW_ADDR-1:0] i_id_rs1_addr,
  input  logic [BW_ADDR-1:0] i_id_rd_addr,
  input  logic               i_id_rd_en,
  output logic [BW_ADDR-1:0] o_rf_rd_addr0,
  output logic [BW_ADDR-1:0] o_rf_rd_addr1,
  input  logic [BW_DATA-1:0] i_rf_rd_data0,
  input  logic [BW_DATA-1:0] i_rf_rd_data1,
  input  logic               i_wb_valid,
  input  logic [BW_ADDR-1:0] i_wb_addr,
  input  logic [BW_DATA-1:0] i_wb_data,
  output logic               o_ex_valid,
  input  logic               i_ex_ready,
  output logic [BW_DATA-1:0] o_ex_op0,
  output logic [BW_DATA-1:0] o_ex_op1,
  output logic [BW_ADDR-1:0] o_ex_rd_addr,
  output logic               o_ex_rd_en,
  output logic               o_stall
);

  localparam int NREG = 1 << BW_ADDR;

  logic [NREG-1:0]    sb_q, sb_d;
  logic               ex_valid_q, ex_valid_d;
  logic [BW_DATA-1:0] op0_q, op0_d;
  logic [BW_DATA-1:0] op1_q, op1_d;
  logic [BW_ADDR-1:0] rd_addr_q, rd_addr_d;
  logic               rd_en_q, rd_en_d;

  logic byp0, byp1, wb_hit_rd, hazard, accept;

  function automatic logic [BW_DATA-1:0] sel_operand(input logic               byp,
                                                     input logic [BW_DATA-1:0] wb,
                                                     input logic [BW_DATA-1:0] rf);
    return byp ? wb : rf;
  endfunction

  assign o_rf_rd_addr0 = i_id_rs0_addr;
  assign o_rf_rd_addr1 = i_id_rs1_addr;

`ifdef RF_BYPASS_EN
  assign byp0 = i_wb_valid && (i_wb_addr == i_id_rs0_addr);
  assign byp1 = i_wb_valid && (i_wb_addr == i_id_rs1_addr);
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  // A writer retiring this cycle releases its WAW hold on rd immediately.
  assign wb_hit_rd = i_wb_valid && (i_wb_addr == i_id_rd_addr);

  assign hazard = (sb_q[i_id_rs0_addr] && !byp0) ||
                  (sb_q[i_id_rs1_addr] && !byp1) ||
                  (i_id_rd_en && sb_q[i_id_rd_addr] && !wb_hit_rd);

  assign o_id_ready = (!ex_valid_q || i_ex_ready) && !hazard;
  assign accept     = i_id_valid && o_id_ready;
  assign o_stall    = i_id_valid && hazard;

  // Fetch -> output buffer boundary
  always_comb begin
    ex_valid_d = accept || (ex_valid_q && !i_ex_ready);
    op0_d      = op0_q;
    op1_d      = op1_q;
    rd_addr_d  = rd_addr_q;
    rd_en_d    = rd_en_q;
    if (accept) begin
      op0_d     = sel_operand(byp0, i_wb_data, i_rf_rd_data0);
      op1_d     = sel_operand(byp1, i_wb_data, i_rf_rd_data1);
      rd_addr_d = i_id_rd_addr;
      rd_en_d   = i_id_rd_en;
    end
  end

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (i_wb_valid) sb_d[i_wb_addr] = 1'b0;
    if (accept && i_id_rd_en) sb_d[i_id_rd_addr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sb_q       <= '0;
      ex_valid_q <= 1'b0;
      op0_q      <= '0;
      op1_q      <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
    end else begin
      sb_q       <= sb_d;
      ex_valid_q <= ex_valid_d;
      op0_q      <= op0_d;
      op1_q      <= op1_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
    end
  end

  assign o_ex_valid   = ex_valid_q;
  assign o_ex_op0     = op0_q;
  assign o_ex_op1     = op1_q;
  assign o_ex_rd_addr = rd_addr_q;
  assign o_ex_rd_en   = rd_en_q;

endmodule
